// File: rtl/fetch_unit.sv
// Owns the PC, the instruction register and the status register, and fetches
// instructions over a req/ack handshake that gives up after TIMEOUT cycles.
module fetch_unit #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 32,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_rst,
  input  logic               pc_write,
  input  logic               pc_sel,
  input  logic               br_sel,
  input  logic               ir_load,
  input  logic               stat_en,
  input  logic [3:0]         alu_stat,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [INSTR_W-1:0] ir_out,
  output logic [3:0]         opcode,
  output logic [3:0]         mm,
  output logic [15:0]        imm,
  output logic [3:0]         stat,
  output logic               br_taken,
  output logic               fetch_busy,
  output logic               fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t             state, state_nxt;
  logic [7:0]         wait_cnt;
  logic               start_fetch;
  logic               ack_hit;
  logic               tmo_hit;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_nxt;
  logic [ADDR_W-1:0]  imm_abs;
  logic [ADDR_W-1:0]  imm_rel;
  logic [INSTR_W-1:0] ir_q;
  logic [3:0]         stat_q;

  assign pc_out = pc_q;
  assign ir_out = ir_q;
  assign stat   = stat_q;
  assign opcode = ir_q[31:28];
  assign mm     = ir_q[27:24];
  assign imm    = ir_q[15:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // An ack arriving on the last allowed cycle still wins over the timeout.
  always_comb begin
    state_nxt   = state;
    start_fetch = 1'b0;
    ack_hit     = 1'b0;
    tmo_hit     = 1'b0;
    case (state)
      IDLE: begin
        if (ir_load) begin
          start_fetch = 1'b1;
          state_nxt   = REQ;
        end
      end
      REQ: begin
        if (imem_ack) begin
          ack_hit   = 1'b1;
          state_nxt = DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      fetch_busy <= 1'b0;
      fetch_err  <= 1'b0;
      wait_cnt   <= '0;
      ir_q       <= '0;
    end else begin
      if (start_fetch) begin
        imem_addr  <= pc_q;
        imem_req   <= 1'b1;
        fetch_busy <= 1'b1;
        wait_cnt   <= '0;
      end else if (ack_hit) begin
        ir_q       <= imem_rdata;
        imem_req   <= 1'b0;
        fetch_busy <= 1'b0;
      end else if (tmo_hit) begin
        ir_q       <= '0;
        fetch_err  <= 1'b1;
        imem_req   <= 1'b0;
        fetch_busy <= 1'b0;
      end else if (state == REQ) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  // Targets wrap modulo 2^ADDR_W; the relative form sign-extends imm first.
  assign imm_abs = ADDR_W'(imm);
  assign imm_rel = ADDR_W'(signed'(imm));

  always_comb begin
    pc_nxt = pc_q;
    if (pc_rst) begin
      pc_nxt = '0;
    end else if (pc_write) begin
      if (!pc_sel) begin
        pc_nxt = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else if (!br_sel) begin
        pc_nxt = imm_abs;
      end else begin
        pc_nxt = pc_q + imm_rel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= '0;
      stat_q <= '0;
    end else begin
      pc_q <= pc_nxt;
      if (stat_en) begin
        stat_q <= alu_stat;
      end
    end
  end

  always_comb begin
    br_taken = 1'b0;
    case (opcode)
      4'd4, 4'd5: br_taken =  |(mm & stat_q);
      4'd6, 4'd7: br_taken = ~|(mm & stat_q);
      default:    br_taken = 1'b0;
    endcase
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Responder side of the SISC control interface. Acts on the controller's PC/IR strobes (pc_rst, pc_write, pc_sel, br_sel, ir_load) and feeds decoded fields (opcode, mm) and latched status (stat) back to it.
- Owns the program counter, the instruction register and the status register.
- Runs a request/acknowledge fetch handshake to instruction memory, with a bounded wait.
- Sits between the controller FSM, the ALU status output and instruction memory.

Parameters:
- ADDR_W, 16, PC and instruction-memory address width.
- INSTR_W, 32, instruction width. Field layout: opcode [31:28], mm [27:24], imm [15:0].
- TIMEOUT, 15, maximum cycles to wait for imem_ack before declaring a fetch error (1..255).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc_rst  input  1  synchronous PC clear strobe from the controller.
- pc_write  input  1  PC update strobe.
- pc_sel  input  1  0: PC+1; 1: branch target.
- br_sel  input  1  0: absolute target (imm); 1: relative target (PC + sign-extended imm).
- ir_load  input  1  start-fetch strobe.
- stat_en  input  1  latch alu_stat into the status register.
- alu_stat  input  4  ALU flags {C,N,V,Z}.
- imem_rdata  input  INSTR_W  instruction memory read data; valid when imem_ack=1.
- imem_ack  input  1  memory acknowledge.
- imem_req  output  1  memory request.
- imem_addr  output  ADDR_W  fetch address, held stable while imem_req=1.
- pc_out  output  ADDR_W  current PC.
- ir_out  output  INSTR_W  instruction register.
- opcode  output  4  ir_out[31:28].
- mm  output  4  ir_out[27:24].
- imm  output  16  ir_out[15:0].
- stat  output  4  status register.
- br_taken  output  1  branch condition result (combinational).
- fetch_busy  output  1  high while a fetch is outstanding.
- fetch_err  output  1  sticky fetch-timeout flag.

Behaviour:
- Reset (rst=1, asynchronous): PC=0, IR=0 (NOOP), stat=0, imem_req=0, imem_addr=0, fetch_busy=0, fetch_err=0, wait counter=0, FSM=IDLE. A fetch in progress is aborted immediately; there is no pending ack bookkeeping.
- Fetch FSM states: IDLE, REQ, DONE.
  - IDLE: ir_load=1 latches imem_addr<=PC, sets imem_req=1 and fetch_busy=1, clears the counter, and moves to REQ.
  - REQ: imem_req stays high and imem_addr stays stable.
    - imem_ack=1: IR<=imem_rdata, imem_req=0, fetch_busy=0, go to DONE. An ack in the first REQ cycle gives 2-cycle strobe-to-IR latency.
    - Counter reaches TIMEOUT without ack: IR<=0 (NOOP), fetch_err<=1, imem_req=0, fetch_busy=0, go to DONE.
  - DONE: go to IDLE on the next cycle unconditionally.
  - ir_load in REQ or DONE is ignored, never queued.
- imem_ack while in IDLE or DONE is ignored.
- fetch_err clears only on rst.
- PC update priority is pc_rst > pc_write.
  - pc_rst=1: PC<=0.
  - pc_write & !pc_sel: PC<=PC+1.
  - pc_write & pc_sel & !br_sel: PC<=imm[ADDR_W-1:0].
  - pc_write & pc_sel & br_sel: PC<=PC+sext(imm).
  - All PC arithmetic is modulo 2^ADDR_W, so 0xFFFF+1=0x0000 and 0x0002+0xFFFE=0x0000.
- A PC update during REQ is permitted and does not disturb imem_addr.
- Status register: stat<=alu_stat when stat_en=1, otherwise hold.
- br_taken uses the current stat, not the incoming alu_stat:
  - opcode 4 or 5: br_taken = |(mm & stat).
  - opcode 6 or 7: br_taken = ~|(mm & stat).
  - All other opcodes: br_taken = 0.
- opcode, mm and imm are pure slices of IR and change only when IR loads.

Test Plan:
- Reset then ir_load pulse, memory acks on first REQ cycle with 0x1123_0005 -> imem_req high 1 cycle, imem_addr=0, ir_out=0x11230005 two cycles after the strobe, opcode=1, mm=1, imm=5.
- ir_load with ack delayed 4 cycles, second ir_load mid-wait -> single request, addr stable for 5 cycles, second strobe ignored, fetch_busy falls with ack.
- ir_load, no ack ever -> imem_req drops after TIMEOUT=15 cycles, ir_out=0, fetch_err=1 until rst.
- PC=0xFFFF, pc_write pc_sel=0 -> PC=0x0000. PC=0x0010, imm=0xFFF0, pc_sel=1 br_sel=1 -> PC=0x0000. br_sel=0, imm=0x0042 -> PC=0x0042. pc_rst with pc_write together -> PC=0.
- stat_en with alu_stat=4'b0001, IR opcode 4 mm 0001 -> br_taken=1. Opcode 6 same mm -> br_taken=0. alu_stat changes without stat_en -> br_taken unchanged.
- rst asserted mid-REQ -> imem_req=0, fetch_busy=0, PC=0 immediately. A late ack after reset is released leaves IR=0.
